ctrl_conv_input: RTL and testbench

Input-side control for the convolution engine: the AXI-stream receiver that drives `s_ready`, accepts filter and data words from the upstream master, and generates write enables and addresses for the F and X memories. Once a full frame is stored, it raises `conv_start` to the output controller and MAC datapath. It then holds off new input until that controller pulses `conv_done`. It sits in front of the memories, opposite the output controller on the same start/done handshake.

---
 rtl/conv_pkg.sv | 16 +
 rtl/ctrl_conv_input_if.sv | 32 +++
 rtl/addr_counter.sv | 41 ++++
 rtl/ctrl_conv_input.sv | 124 ++++++++++++
 tb/tb_ctrl_conv_input.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution engine's input and output controllers.
package conv_pkg;

  localparam int CONV_F_MEM_SIZE       = 4;
  localparam int CONV_X_MEM_SIZE       = 8;
  localparam int CONV_F_MEM_ADDR_WIDTH = 2;
  localparam int CONV_X_MEM_ADDR_WIDTH = 3;
  localparam int CONV_DATA_WIDTH       = 8;

  typedef enum logic [1:0] {
    LOAD_F = 2'd0,
    LOAD_X = 2'd1,
    CONV   = 2'd2
  } conv_in_state_t;

endpackage

// File: rtl/ctrl_conv_input_if.sv
// Stream, memory-write and start/done signals of the input controller.
// slave: the controller itself; master: the environment around it.
interface ctrl_conv_input_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH       = CONV_DATA_WIDTH,
  parameter int F_MEM_ADDR_WIDTH = CONV_F_MEM_ADDR_WIDTH,
  parameter int X_MEM_ADDR_WIDTH = CONV_X_MEM_ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0]       s_data_in;
  logic                        s_valid;
  logic                        s_ready;
  logic                        conv_done;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        wr_en_f;
  logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f;
  logic                        wr_en_x;
  logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x;
  logic                        conv_start;

  modport slave (
    input  s_data_in, s_valid, conv_done,
    output s_ready, wr_data, wr_en_f, wr_addr_f, wr_en_x, wr_addr_x, conv_start
  );

  modport master (
    output s_data_in, s_valid, conv_done,
    input  s_ready, wr_data, wr_en_f, wr_addr_f, wr_en_x, wr_addr_x, conv_start
  );

endinterface

// File: rtl/addr_counter.sv
// Write-address counter with clear priority over increment and a terminal-count flag.
module addr_counter #(
  parameter int WIDTH = 2,
  parameter int LAST  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(unsigned'(LAST));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise step on increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared by active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_V);

endmodule

// File: rtl/ctrl_conv_input.sv
// Input-side controller of the convolution engine: accepts a frame of filter
// words then data words from an AXI-stream master, writes them into the F and
// X memories, raises conv_start, and blocks input until conv_done.
// Optional macro CONV_F_REUSE_EN: keep the filter after the first frame so
// later frames carry only X words.
module ctrl_conv_input
  import conv_pkg::*;
#(
  parameter int F_MEM_SIZE       = CONV_F_MEM_SIZE,
  parameter int X_MEM_SIZE       = CONV_X_MEM_SIZE,
  parameter int F_MEM_ADDR_WIDTH = CONV_F_MEM_ADDR_WIDTH,
  parameter int X_MEM_ADDR_WIDTH = CONV_X_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH       = CONV_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_conv_input_if.slave   bus
);

  conv_in_state_t              state_q;
  logic                        conv_start_q;
  logic                        ready;
  logic                        accept;
  logic                        en_f;
  logic                        en_x;
  logic                        f_tc;
  logic                        x_tc;
  logic                        f_last;
  logic                        x_last;
  logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
  logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;

  // Ready whenever loading; held low during reset so nothing is accepted.
  always_comb begin
    ready  = reset && (state_q != CONV);
    accept = bus.s_valid && ready;
    en_f   = accept && (state_q == LOAD_F);
    en_x   = accept && (state_q == LOAD_X);
    f_last = en_f && f_tc;
    x_last = en_x && x_tc;
  end

  addr_counter #(
    .WIDTH (F_MEM_ADDR_WIDTH),
    .LAST  (F_MEM_SIZE - 1)
  ) u_f_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (f_last),
    .inc_i (en_f),
    .cnt_o (f_cnt),
    .tc_o  (f_tc)
  );

  addr_counter #(
    .WIDTH (X_MEM_ADDR_WIDTH),
    .LAST  (X_MEM_SIZE - 1)
  ) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (x_last),
    .inc_i (en_x),
    .cnt_o (x_cnt),
    .tc_o  (x_tc)
  );

`ifdef CONV_F_REUSE_EN
  logic filter_loaded_q;

  // Remember that a complete filter is resident in F memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filter_loaded_q <= 1'b0;
    end else if (f_last) begin
      filter_loaded_q <= 1'b1;
    end
  end
`endif

  // Frame sequencing FSM with registered conv_start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD_F;
      conv_start_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_F: begin
          if (f_last) begin
            state_q <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (x_last) begin
            state_q      <= CONV;
            conv_start_q <= 1'b1;
          end
        end
        CONV: begin
          if (bus.conv_done) begin
            conv_start_q <= 1'b0;
`ifdef CONV_F_REUSE_EN
            state_q      <= filter_loaded_q ? LOAD_X : LOAD_F;
`else
            state_q      <= LOAD_F;
`endif
          end
        end
        default: begin
          state_q      <= LOAD_F;
          conv_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready    = ready;
  assign bus.wr_data    = bus.s_data_in;
  assign bus.wr_en_f    = en_f;
  assign bus.wr_addr_f  = f_cnt;
  assign bus.wr_en_x    = en_x;
  assign bus.wr_addr_x  = x_cnt;
  assign bus.conv_start = conv_start_q;

endmodule

// File: tb/tb_ctrl_conv_input.sv
// Directed bench for ctrl_conv_input (F=4, X=8): table-driven first frame,
// then hand sequences for CONV hold-off, stream gaps, stray conv_done,
// mid-frame reset and (when CONV_F_REUSE_EN is defined) filter reuse.
module tb_ctrl_conv_input;

  localparam int NF = 4;
  localparam int NX = 8;
  localparam int NW = NF + NX;
`ifdef CONV_F_REUSE_EN
  localparam int NEXT_K = NF;
`else
  localparam int NEXT_K = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ctrl_conv_input_if bus ();

  ctrl_conv_input dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       en_f;
    logic [1:0] addr_f;
    logic       en_x;
    logic [2:0] addr_x;
    logic       start;
  } vec_t;

  vec_t tbl [NW+1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One loading cycle checked against an expected word index k.
  task automatic run_frame(input int start_k, input int stop_k, input bit gaps,
                           input int done_at, input int off);
    int k = start_k;
    int budget = 0;
    bit v;
    bit done_sent = 1'b0;
    while (k < stop_k && budget < 300) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.s_valid   = v;
      bus.s_data_in = 8'(k + 1 + off);
      bus.conv_done = (k == done_at) && !done_sent;
      if (bus.conv_done) done_sent = 1'b1;
      #4;
      chk("ready", int'(bus.s_ready), 1);
      chk("start", int'(bus.conv_start), 0);
      chk("en_f", int'(bus.wr_en_f), int'(v && k < NF));
      chk("en_x", int'(bus.wr_en_x), int'(v && k >= NF));
      chk("addr_f", int'(bus.wr_addr_f), (k < NF) ? k : 0);
      chk("addr_x", int'(bus.wr_addr_x), (k < NF) ? 0 : k - NF);
      if (v) begin
        chk("data", int'(bus.wr_data), (k + 1 + off) % 256);
        $display("word %0d data %0d en_f %0b af %0d en_x %0b ax %0d",
                 k, bus.wr_data, bus.wr_en_f, bus.wr_addr_f, bus.wr_en_x, bus.wr_addr_x);
      end
      @(posedge clk); #1;
      if (v) k++;
      budget++;
    end
    bus.s_valid   = 1'b0;
    bus.conv_done = 1'b0;
    checks++;
    if (k < stop_k) begin
      errors++;
      $display("FAIL frame_timeout: reached word %0d expected %0d", k, stop_k);
    end
  endtask

  // CONV hold-off with s_valid asserted, then a conv_done pulse.
  task automatic conv_wrap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_valid   = 1'b1;
      bus.s_data_in = 8'hAA;
      bus.conv_done = 1'b0;
      #4;
      chk("conv_ready", int'(bus.s_ready), 0);
      chk("conv_en_f", int'(bus.wr_en_f), 0);
      chk("conv_en_x", int'(bus.wr_en_x), 0);
      chk("conv_start", int'(bus.conv_start), 1);
      @(posedge clk); #1;
    end
    bus.conv_done = 1'b1;
    #4;
    chk("done_start", int'(bus.conv_start), 1);
    chk("done_ready", int'(bus.s_ready), 0);
    $display("conv_done pulse after %0d hold cycles", n);
    @(posedge clk); #1;
    bus.conv_done = 1'b0;
    bus.s_valid   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      tbl[i].valid  = 1'b1;
      tbl[i].data   = 8'(i + 1);
      tbl[i].ready  = 1'b1;
      tbl[i].en_f   = (i < NF);
      tbl[i].addr_f = (i < NF) ? 2'(i) : 2'd0;
      tbl[i].en_x   = (i >= NF);
      tbl[i].addr_x = (i < NF) ? 3'd0 : 3'(i - NF);
      tbl[i].start  = 1'b0;
    end
    tbl[NW] = '{valid: 1'b1, data: 8'h55, ready: 1'b0, en_f: 1'b0, addr_f: 2'd0,
                en_x: 1'b0, addr_x: 3'd0, start: 1'b1};

    reset         = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_data_in = 8'h77;
    bus.conv_done = 1'b0;
    @(posedge clk); #1;

    // Held in reset: ready forced low, no writes.
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("rst_ready", int'(bus.s_ready), 0);
      chk("rst_en_f", int'(bus.wr_en_f), 0);
      chk("rst_en_x", int'(bus.wr_en_x), 0);
      chk("rst_addr_f", int'(bus.wr_addr_f), 0);
      chk("rst_addr_x", int'(bus.wr_addr_x), 0);
      chk("rst_start", int'(bus.conv_start), 0);
      @(posedge clk); #1;
    end

    // First frame, continuous valid, words 1..12 from the table.
    reset = 1'b1;
    for (int i = 0; i <= NW; i++) begin
      bus.s_valid   = tbl[i].valid;
      bus.s_data_in = tbl[i].data;
      #4;
      chk("t_ready", int'(bus.s_ready), int'(tbl[i].ready));
      chk("t_en_f", int'(bus.wr_en_f), int'(tbl[i].en_f));
      chk("t_addr_f", int'(bus.wr_addr_f), int'(tbl[i].addr_f));
      chk("t_en_x", int'(bus.wr_en_x), int'(tbl[i].en_x));
      chk("t_addr_x", int'(bus.wr_addr_x), int'(tbl[i].addr_x));
      chk("t_start", int'(bus.conv_start), int'(tbl[i].start));
      if (tbl[i].en_f || tbl[i].en_x) chk("t_data", int'(bus.wr_data), int'(tbl[i].data));
      $display("vec %0d data %0d ready %0b en_f %0b af %0d en_x %0b ax %0d start %0b",
               i, bus.s_data_in, bus.s_ready, bus.wr_en_f, bus.wr_addr_f,
               bus.wr_en_x, bus.wr_addr_x, bus.conv_start);
      @(posedge clk); #1;
    end
    conv_wrap(19);

    // Random gaps in s_valid.
    run_frame(NEXT_K, NW, 1'b1, -1, 8'h20);
    conv_wrap(2);

    // Stray conv_done during LOAD_X is ignored.
    run_frame(NEXT_K, NW, 1'b0, NF + 2, 8'h30);
    conv_wrap(1);

    // Reset after six accepts.
    run_frame(NEXT_K, NEXT_K + 6, 1'b0, -1, 8'h40);
    reset       = 1'b0;
    bus.s_valid = 1'b1;
    #4;
    chk("mid_rst_ready", int'(bus.s_ready), 0);
    chk("mid_rst_en_f", int'(bus.wr_en_f), 0);
    chk("mid_rst_en_x", int'(bus.wr_en_x), 0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    #4;
    chk("post_rst_addr_f", int'(bus.wr_addr_f), 0);
    chk("post_rst_addr_x", int'(bus.wr_addr_x), 0);
    chk("post_rst_ready", int'(bus.s_ready), 0);
    chk("post_rst_start", int'(bus.conv_start), 0);
    $display("mid-frame reset applied");
    @(posedge clk); #1;
    reset = 1'b1;

    // Full frame again from F address 0, regardless of filter reuse.
    run_frame(0, NW, 1'b0, -1, 8'h80);
    conv_wrap(1);
    run_frame(NEXT_K, NW, 1'b1, -1, 8'h90);
    conv_wrap(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
